// File: rtl/llc_localmem_ctrl_if.sv
// Request channels, memory strobes and status of the LLC local-memory controller.
// master = requester/memory side, slave = the controller.
interface llc_localmem_ctrl_if #(
    parameter int SET_BITS = 10,
    parameter int WAY_BITS = 4
);
    logic                         rd_req_valid;
    logic                         rd_req_ready;
    logic [SET_BITS-1:0]          rd_req_set;
    logic                         wr_req_valid;
    logic                         wr_req_ready;
    logic [SET_BITS+WAY_BITS-1:0] wr_req_addr;
    logic                         mem_rd_en;
    logic [SET_BITS-1:0]          mem_rd_set;
    logic                         mem_wr_en;
    logic [SET_BITS+WAY_BITS-1:0] mem_wr_addr;
    logic                         mem_wr_init;
    logic                         rd_rsp_valid;
    logic                         init_done;

    modport master (
        output rd_req_valid, rd_req_set, wr_req_valid, wr_req_addr,
        input  rd_req_ready, wr_req_ready, mem_rd_en, mem_rd_set,
        input  mem_wr_en, mem_wr_addr, mem_wr_init, rd_rsp_valid, init_done
    );

    modport slave (
        input  rd_req_valid, rd_req_set, wr_req_valid, wr_req_addr,
        output rd_req_ready, wr_req_ready, mem_rd_en, mem_rd_set,
        output mem_wr_en, mem_wr_addr, mem_wr_init, rd_rsp_valid, init_done
    );
endinterface

// File: rtl/llc_localmem_ctrl.sv
// LLC directory local-memory controller: optional zeroing sweep, then write-priority
// read/write arbitration with read anti-starvation. Optional sweep: LLC_INIT_SWEEP_EN.
module llc_localmem_ctrl #(
    parameter int SET_BITS   = 10,
    parameter int WAY_BITS   = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    llc_localmem_ctrl_if.slave bus
);
    localparam int ADDR_BITS = SET_BITS + WAY_BITS;
    localparam int CNT_BITS  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_BITS-1:0] STARVE_LIM = CNT_BITS'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e               state_r;
    logic                 started_r;
    logic [CNT_BITS-1:0]  starve_r;
    logic                 rsp_r;
    logic                 starved_s;
    logic                 rd_ready_s;
    logic                 wr_ready_s;
    logic                 rd_grant_s;
    logic                 wr_grant_s;
    logic                 sweep_wr_s;
    logic                 sweep_last_s;
    logic [ADDR_BITS-1:0] sweep_addr_s;

`ifdef LLC_INIT_SWEEP_EN
    logic [ADDR_BITS-1:0] sweep_r;

    // Sweep address, way index in the low bits so it varies fastest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_r <= {ADDR_BITS{1'b0}};
        end else if (sweep_wr_s) begin
            sweep_r <= sweep_r + ADDR_BITS'(1);
        end else begin
            sweep_r <= sweep_r;
        end
    end

    assign sweep_wr_s   = (state_r == ST_INIT) && started_r;
    assign sweep_last_s = sweep_wr_s && (sweep_r == {ADDR_BITS{1'b1}});
    assign sweep_addr_s = sweep_r;
`else
    // Without the sweep, INIT only waits one cycle after the first post-reset edge.
    assign sweep_wr_s   = 1'b0;
    assign sweep_last_s = (state_r == ST_INIT) && started_r;
    assign sweep_addr_s = {ADDR_BITS{1'b0}};
`endif

    // Readies depend on state and the competing channel only, never on their own valid.
    always_comb begin
        starved_s = (starve_r >= STARVE_LIM);
        if (state_r == ST_RUN) begin
            rd_ready_s = !bus.wr_req_valid || starved_s;
            wr_ready_s = !(bus.rd_req_valid && starved_s);
        end else begin
            rd_ready_s = 1'b0;
            wr_ready_s = 1'b0;
        end
        rd_grant_s = rd_ready_s && bus.rd_req_valid;
        wr_grant_s = wr_ready_s && bus.wr_req_valid;
    end

    // Memory strobes: sweep writes first, otherwise the granted request passes through.
    always_comb begin
        bus.rd_req_ready = rd_ready_s;
        bus.wr_req_ready = wr_ready_s;
        bus.mem_rd_en    = rd_grant_s;
        if (rd_grant_s) begin
            bus.mem_rd_set = bus.rd_req_set;
        end else begin
            bus.mem_rd_set = {SET_BITS{1'b0}};
        end
        if (sweep_wr_s) begin
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_addr = sweep_addr_s;
            bus.mem_wr_init = 1'b1;
        end else if (wr_grant_s) begin
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_addr = bus.wr_req_addr;
            bus.mem_wr_init = 1'b0;
        end else begin
            bus.mem_wr_en   = 1'b0;
            bus.mem_wr_addr = {ADDR_BITS{1'b0}};
            bus.mem_wr_init = 1'b0;
        end
        bus.rd_rsp_valid = rsp_r;
        bus.init_done    = (state_r == ST_RUN);
    end

    // Controller FSM with starvation counter and one-cycle read response pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_INIT;
            started_r <= 1'b0;
            starve_r  <= {CNT_BITS{1'b0}};
            rsp_r     <= 1'b0;
        end else begin
            started_r <= 1'b1;
            rsp_r     <= rd_grant_s;
            case (state_r)
                ST_INIT: begin
                    starve_r <= {CNT_BITS{1'b0}};
                    if (sweep_last_s) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                    if (rd_grant_s || !bus.rd_req_valid) begin
                        starve_r <= {CNT_BITS{1'b0}};
                    end else if (wr_grant_s) begin
                        starve_r <= starve_r + CNT_BITS'(1);
                    end else begin
                        starve_r <= starve_r;
                    end
                end
                default: begin
                    state_r  <= ST_INIT;
                    starve_r <= {CNT_BITS{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_llc_localmem_ctrl.sv
// Self-checking bench for llc_localmem_ctrl: init behaviour, directed arbitration cases,
// randomized traffic against a rule-level model, and asynchronous reset.
module tb_llc_localmem_ctrl;
    localparam int S   = 3;
    localparam int W   = 2;
    localparam int A   = S + W;
    localparam int MAX = 4;
    localparam int OW  = S + A + 7;
`ifdef LLC_INIT_SWEEP_EN
    localparam bit SWEEP_ON = 1'b1;
    localparam int DONE_CYC = (1 << A) + 1;
`else
    localparam bit SWEEP_ON = 1'b0;
    localparam int DONE_CYC = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    llc_localmem_ctrl_if #(.SET_BITS(S), .WAY_BITS(W)) bus ();

    llc_localmem_ctrl #(.SET_BITS(S), .WAY_BITS(W), .STARVE_MAX(MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] obs();
        return {bus.rd_req_ready, bus.wr_req_ready, bus.mem_rd_en, bus.mem_rd_set,
                bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_init, bus.rd_rsp_valid, bus.init_done};
    endfunction

    function automatic logic [OW-1:0] mk(input logic rr, input logic wr, input logic re,
                                         input logic [S-1:0] rs, input logic we,
                                         input logic [A-1:0] wa, input logic wi,
                                         input logic rv, input logic id);
        return {rr, wr, re, rs, we, wa, wi, rv, id};
    endfunction

    task automatic drive(input logic rv, input logic [S-1:0] rs, input logic wv, input logic [A-1:0] wa);
        bus.rd_req_valid = rv;
        bus.rd_req_set   = rs;
        bus.wr_req_valid = wv;
        bus.wr_req_addr  = wa;
    endtask

    // Keeps reset low one more cycle with idle inputs, then releases it on a falling edge.
    task automatic hold_and_release();
        @(negedge clk);
        drive(1'b0, S'(0), 1'b0, A'(0));
        #1;
        checks++;
        if (obs() !== {OW{1'b0}}) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", obs(), {OW{1'b0}});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, S'($urandom), 1'b1, A'($urandom));
        #1;
        checks++;
        if (obs() !== {OW{1'b0}}) begin
            failures++;
            $display("FAIL reset_force got=%h exp=%h", obs(), {OW{1'b0}});
        end
        hold_and_release();
    endtask

    // Entered right after reset release; cycle 0 is the cycle before the first edge.
    task automatic test_init();
        logic [OW-1:0] e;
        bit            wr;
        for (int c = 0; c <= DONE_CYC; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            wr = SWEEP_ON && (c >= 1) && (c < DONE_CYC);
            if (c == DONE_CYC)
                e = mk(1'b1, 1'b1, 1'b0, S'(0), 1'b0, A'(0), 1'b0, 1'b0, 1'b1);
            else if (wr)
                e = mk(1'b0, 1'b0, 1'b0, S'(0), 1'b1, A'(c - 1), 1'b1, 1'b0, 1'b0);
            else
                e = {OW{1'b0}};
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL init cyc=%0d got=%h exp=%h", c, obs(), e);
            end
        end
    endtask

    task automatic test_read();
        logic [OW-1:0] e [3];
        e[0] = mk(1'b1, 1'b1, 1'b1, S'(5), 1'b0, A'(0), 1'b0, 1'b0, 1'b1);
        e[1] = mk(1'b1, 1'b1, 1'b0, S'(0), 1'b0, A'(0), 1'b0, 1'b1, 1'b1);
        e[2] = mk(1'b1, 1'b1, 1'b0, S'(0), 1'b0, A'(0), 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(c == 0, (c == 0) ? S'(5) : S'(0), 1'b0, A'(0));
            #1;
            checks++;
            if (obs() !== e[c]) begin
                failures++;
                $display("FAIL read cyc=%0d got=%h exp=%h", c, obs(), e[c]);
            end
        end
    endtask

    task automatic test_collision();
        logic [OW-1:0] e [3];
        e[0] = mk(1'b0, 1'b1, 1'b0, S'(0), 1'b1, {3'd3, 2'd2}, 1'b0, 1'b0, 1'b1);
        e[1] = mk(1'b1, 1'b1, 1'b1, S'(3), 1'b0, A'(0), 1'b0, 1'b0, 1'b1);
        e[2] = mk(1'b1, 1'b1, 1'b0, S'(0), 1'b0, A'(0), 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(c < 2, (c < 2) ? S'(3) : S'(0), c == 0, (c == 0) ? {3'd3, 2'd2} : A'(0));
            #1;
            checks++;
            if (obs() !== e[c]) begin
                failures++;
                $display("FAIL collision cyc=%0d got=%h exp=%h", c, obs(), e[c]);
            end
        end
    endtask

    // Writes always valid, read of set 6 waiting: MAX write grants, then the read.
    task automatic test_starve();
        logic [A-1:0]  wa;
        logic [OW-1:0] e;
        bit            rd;
        wa = A'($urandom);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c != 5) wa = A'($urandom);
            drive(c <= MAX, S'(6), 1'b1, wa);
            #1;
            rd = (c == MAX);
            e = mk(rd, !rd, rd, rd ? S'(6) : S'(0), !rd, rd ? A'(0) : wa, 1'b0, c == MAX + 1, 1'b1);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL starve cyc=%0d got=%h exp=%h", c, obs(), e);
            end
        end
        @(negedge clk);
        drive(1'b0, S'(0), 1'b0, A'(0));
    endtask

    // Requests are held until granted; the model applies the arbitration rules directly.
    task automatic test_random();
        logic          rv, wv;
        logic [S-1:0]  rs;
        logic [A-1:0]  wa;
        int            writes_while_waiting;
        bit            prev_read, rd_g, wr_g, rd_rdy, wr_rdy;
        logic [OW-1:0] e;
        rv = 1'b0; wv = 1'b0; rs = S'(0); wa = A'(0);
        writes_while_waiting = 0;
        prev_read = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!rv) begin rv = ($urandom_range(0, 99) < 45); rs = S'($urandom); end
            if (!wv) begin wv = ($urandom_range(0, 99) < 80); wa = A'($urandom); end
            drive(rv, rs, wv, wa);
            #1;
            rd_rdy = !wv || (writes_while_waiting >= MAX);
            wr_rdy = !(rv && writes_while_waiting >= MAX);
            rd_g   = rv && rd_rdy;
            wr_g   = wv && wr_rdy;
            e = mk(rd_rdy, wr_rdy, rd_g, rd_g ? rs : S'(0), wr_g, wr_g ? wa : A'(0),
                   1'b0, prev_read, 1'b1);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs(), e);
            end
            if (rd_g || !rv) writes_while_waiting = 0;
            else if (wr_g) writes_while_waiting++;
            prev_read = rd_g;
            if (rd_g) rv = 1'b0;
            if (wr_g) wv = 1'b0;
        end
        @(negedge clk);
        drive(1'b0, S'(0), 1'b0, A'(0));
    endtask

    // Reset lands while a read response is outstanding; it must vanish and INIT restart.
    task automatic test_reset_run();
        @(negedge clk);
        drive(1'b1, S'(2), 1'b0, A'(0));
        @(negedge clk);
        drive(1'b0, S'(0), 1'b0, A'(0));
        #1;
        checks++;
        if (bus.rd_rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL run_rsp_before_reset got=%b exp=1", bus.rd_rsp_valid);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== {OW{1'b0}}) begin
            failures++;
            $display("FAIL run_reset_force got=%h exp=%h", obs(), {OW{1'b0}});
        end
        hold_and_release();
        test_init();
    endtask

`ifdef LLC_INIT_SWEEP_EN
    task automatic test_reset_mid_sweep();
        test_reset();
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
        end
        checks++;
        if (bus.mem_wr_addr !== A'(3) || bus.mem_wr_en !== 1'b1) begin
            failures++;
            $display("FAIL sweep_at3 got=%h/%b exp=3/1", bus.mem_wr_addr, bus.mem_wr_en);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== {OW{1'b0}}) begin
            failures++;
            $display("FAIL sweep_reset_force got=%h exp=%h", obs(), {OW{1'b0}});
        end
        hold_and_release();
        test_init();
    endtask
`endif

    initial begin
        drive(1'b0, S'(0), 1'b0, A'(0));
        test_reset();
        test_init();
        test_read();
        test_collision();
        test_starve();
        test_random();
        test_reset_run();
`ifdef LLC_INIT_SWEEP_EN
        test_reset_mid_sweep();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
